// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: instruction fields, opcodes, fetch states.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 8;

    // Instruction field bit positions: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm
    localparam int unsigned OP_MSB  = 7;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RS_MSB  = 5;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_MSB  = 3;
    localparam int unsigned RT_LSB  = 2;
    localparam int unsigned IMM_MSB = 1;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned OP_W    = OP_MSB - OP_LSB + 1;
    localparam int unsigned IMM_W   = IMM_MSB - IMM_LSB + 1;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_LW  = 2'b01;
    localparam logic [OP_W-1:0] OP_SW  = 2'b10;
    localparam logic [OP_W-1:0] OP_J   = 2'b11;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_HALT  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_e;

    // Sign-extend the 2-bit immediate to an address-width offset
    function automatic logic [ADDR_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC computation: sequential PC+1, or PC+1+sext(imm) for jumps; flags jump-to-self.
module next_pc
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               is_self_jump
);

    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic             unused_reg_fields;

    // Register fields do not affect control flow
    assign unused_reg_fields = ^instruction[RS_MSB:RT_LSB];

    // Target select and self-loop detection
    always_comb begin
        op           = instruction[OP_MSB:OP_LSB];
        imm          = instruction[IMM_MSB:IMM_LSB];
        next_pc      = pc + ADDR_W'(1);
        is_self_jump = 1'b0;
        if (op == OP_J) begin
            next_pc      = pc + ADDR_W'(1) + sext_imm(imm);
            is_self_jump = (next_pc == pc);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC / fetch stage: drives IMEM address, registers the returned byte into IR,
// hands IR to decode over valid/ready, resolves jumps, detects halt and fault.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       MEM_DEPTH = 32,
    parameter logic [ADDR_W-1:0] PC_RESET  = 8'h00,
    parameter bit                LOOP_HALT = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    output logic [ADDR_W-1:0]  read_address,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               halted,
    output logic               fault,
    output logic [7:0]         fetch_count
);

    localparam int unsigned CNT_W = 8;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ADDR_W-1:0]  jump_pc_c;
    logic               self_jump_c;
    logic               issue_c;
    logic               pc_fault_c;

    next_pc u_next_pc (
        .pc           (pc_q),
        .instruction  (instruction),
        .next_pc      (jump_pc_c),
        .is_self_jump (self_jump_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FS_IDLE;
            pc_q       <= PC_RESET;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            ir_pc_q    <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ir_pc_q    <= ir_pc_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    // Next-state, issue decision and IR handshake; fault check outranks issue
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ir_pc_d    = ir_pc_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        count_d    = count_q;
        issue_c    = 1'b0;
        pc_fault_c = (32'(pc_q) >= MEM_DEPTH);

        case (state_q)
            FS_IDLE: begin
                if (run) state_d = FS_RUN;
            end
            FS_RUN: begin
                if (!run) begin
                    state_d = FS_IDLE;
                end else if (pc_fault_c) begin
                    state_d = FS_FAULT;
                    fault_d = 1'b1;
                end else if (!ir_valid_q || ir_ready) begin
                    issue_c = 1'b1;
                    if (LOOP_HALT && self_jump_c) begin
                        state_d  = FS_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            FS_HALT:  state_d = FS_HALT;
            FS_FAULT: state_d = FS_FAULT;
            default:  state_d = FS_IDLE;
        endcase

        if (issue_c) begin
            ir_d       = instruction;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = jump_pc_c;
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
        end else if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
        end
    end

    assign read_address = pc_q;
    assign ir           = ir_q;
    assign ir_valid     = ir_valid_q;
    assign ir_pc        = ir_pc_q;
    assign halted       = halted_q;
    assign fault        = fault_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan scenarios plus randomized run/ready
// traffic, checked against an architectural-trace reference model.
module tb_fetch_unit;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic       ir_ready = 1'b0;
    logic [7:0] read_address, instruction, ir, ir_pc, fetch_count;
    logic       ir_valid, halted, fault;

    logic       rst_f_n = 1'b0;
    logic       run_f = 1'b0;
    logic       rdy_f = 1'b0;
    logic [7:0] ra_f, instr_f, ir_f, ir_pc_f, cnt_f;
    logic       ir_valid_f, halted_f, fault_f;

    logic [7:0] imem   [256];
    logic [7:0] imem_f [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb instruction = imem[read_address];
    always_comb instr_f     = imem_f[ra_f];

    fetch_unit dut (
        .clk (clk), .reset_n (reset_n), .run (run),
        .read_address (read_address), .instruction (instruction),
        .ir (ir), .ir_valid (ir_valid), .ir_ready (ir_ready), .ir_pc (ir_pc),
        .halted (halted), .fault (fault), .fetch_count (fetch_count)
    );

    fetch_unit #(.MEM_DEPTH(4)) dut_f (
        .clk (clk), .reset_n (rst_f_n), .run (run_f),
        .read_address (ra_f), .instruction (instr_f),
        .ir (ir_f), .ir_valid (ir_valid_f), .ir_ready (rdy_f), .ir_pc (ir_pc_f),
        .halted (halted_f), .fault (fault_f), .fetch_count (cnt_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The program is walked architecturally into the list of PCs that will be
    // issued; the cycle model only decides when the next one is issued.
    int   trace[$];
    int   end_pc;
    bit   end_halt, end_fault;
    bit   m_active, m_halt, m_fault, m_valid, m_issued;
    logic [7:0] m_ir, m_irpc, m_cnt;

    function automatic void build_trace(input int depth);
        int pc, imm, tgt;
        logic [7:0] ins;
        bit done;
        trace.delete();
        end_halt = 0; end_fault = 0; end_pc = 0;
        pc = 0; done = 0;
        while (!done) begin
            if (pc >= depth) begin
                end_fault = 1; end_pc = pc; done = 1;
            end else if (trace.size() >= 1024) begin
                end_pc = pc; done = 1;
            end else begin
                trace.push_back(pc);
                ins = imem[pc];
                if (ins[7:6] == 2'b11) begin
                    imm = int'(ins[1:0]);
                    if (imm >= 2) imm -= 4;
                    tgt = (pc + 1 + imm) & 255;
                    if (tgt == pc) begin
                        end_halt = 1; end_pc = pc; done = 1;
                    end else begin
                        pc = tgt;
                    end
                end else begin
                    pc = (pc + 1) & 255;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        m_active = 0; m_halt = 0; m_fault = 0; m_valid = 0; m_issued = 0;
        m_ir = 8'h00; m_irpc = 8'h00; m_cnt = 8'h00;
        build_trace(DEPTH);
    endfunction

    function automatic logic [7:0] exp_ra();
        if (trace.size() > 0) return 8'(trace[0]);
        return 8'(end_pc);
    endfunction

    // Advance the model by one clock using the inputs about to be sampled
    function automatic void model_step();
        bit go;
        int e;
        go = 0;
        m_issued = 0;
        if (!m_halt && !m_fault) begin
            if (!m_active)               m_active = run;
            else if (!run)               m_active = 0;
            else if (trace.size() == 0)  m_fault = end_fault;
            else if (!m_valid || ir_ready) go = 1;
        end
        if (go) begin
            e = trace.pop_front();
            m_ir = imem[e];
            m_irpc = 8'(e);
            m_valid = 1;
            m_issued = 1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (trace.size() == 0 && end_halt) m_halt = 1;
        end else if (m_valid && ir_ready) begin
            m_valid = 0;
        end
    endfunction

    task automatic compare_all();
        check("read_address", 32'(read_address), 32'(exp_ra()));
        check("ir_valid",     32'(ir_valid),     32'(m_valid));
        check("ir",           32'(ir),           32'(m_ir));
        check("ir_pc",        32'(ir_pc),        32'(m_irpc));
        check("halted",       32'(halted),       32'(m_halt));
        check("fault",        32'(fault),        32'(m_fault));
        check("fetch_count",  32'(fetch_count),  32'(m_cnt));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; run = 1'b0; ir_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;
    endtask

    task automatic load_team_program();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[0] = 8'h49;
        imem[1] = 8'hC1;
        imem[2] = 8'hC3;
        imem[3] = 8'hA9;
        for (int i = 4; i < 13; i++) imem[i] = 8'(8'h10 + i);
        imem[13] = 8'hC3;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   exp_boot [13] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
        logic [7:0] exp_ir3 [3] = '{8'h49, 8'hC1, 8'hA9};
        int   obs_pc[$];
        logic [7:0] obs_ir[$];
        int   last_pc;

        for (int i = 0; i < 256; i++) imem_f[i] = 8'h00;

        // Boot trace with the team program
        load_team_program();
        do_reset();
        run = 1'b1; ir_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (m_issued) begin
                obs_pc.push_back(int'(ir_pc));
                obs_ir.push_back(ir);
                if (ir == 8'hC1) check("jump_plus1_ra", 32'(read_address), 32'd3);
                if (ir == 8'hC3) check("halt_on_issue", 32'(halted), 32'd1);
            end
            if (halted) break;
        end
        check("boot_len", 32'(obs_pc.size()), 32'd13);
        for (int k = 0; k < 13; k++)
            check("boot_pc", (k < obs_pc.size()) ? 32'(obs_pc[k]) : 32'hFFFF_FFFF, 32'(exp_boot[k]));
        for (int k = 0; k < 3; k++)
            check("boot_ir", (k < obs_ir.size()) ? 32'(obs_ir[k]) : 32'hFFFF_FFFF, 32'(exp_ir3[k]));
        check("boot_halted", 32'(halted), 32'd1);
        check("boot_count", 32'(fetch_count), 32'd13);
        repeat (3) cycle();
        check("halt_drained", 32'(ir_valid), 32'd0);

        // Backpressure while 0x49 is held in IR
        do_reset();
        run = 1'b1; ir_ready = 1'b0;
        cycle();
        cycle();
        check("bp_first_ir", 32'(ir), 32'h49);
        repeat (3) begin
            cycle();
            check("bp_ir_hold", 32'(ir), 32'h49);
            check("bp_irpc_hold", 32'(ir_pc), 32'd0);
            check("bp_ra_hold", 32'(read_address), 32'd1);
        end
        ir_ready = 1'b1;
        cycle();
        check("bp_resume_ir", 32'(ir), 32'hC1);
        check("bp_resume_irpc", 32'(ir_pc), 32'd1);

        // Run gating at PC=5
        do_reset();
        run = 1'b1; ir_ready = 1'b1;
        for (int c = 0; c < 20 && exp_ra() != 8'd5; c++) cycle();
        check("rg_at5", 32'(read_address), 32'd5);
        run = 1'b0;
        cycle();
        check("rg_drained", 32'(ir_valid), 32'd0);
        check("rg_hold", 32'(read_address), 32'd5);
        cycle();
        check("rg_hold2", 32'(read_address), 32'd5);
        run = 1'b1;
        cycle();
        cycle();
        check("rg_resume_irpc", 32'(ir_pc), 32'd5);
        check("rg_resume_valid", 32'(ir_valid), 32'd1);

        // Asynchronous reset between edges while running at PC=7
        do_reset();
        run = 1'b1; ir_ready = 1'b1;
        for (int c = 0; c < 20 && exp_ra() != 8'd7; c++) cycle();
        check("ar_at7", 32'(read_address), 32'd7);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ar_ra",     32'(read_address), 32'd0);
        check("ar_ir",     32'(ir), 32'd0);
        check("ar_valid",  32'(ir_valid), 32'd0);
        check("ar_irpc",   32'(ir_pc), 32'd0);
        check("ar_halted", 32'(halted), 32'd0);
        check("ar_fault",  32'(fault), 32'd0);
        check("ar_count",  32'(fetch_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle();
        cycle();
        check("ar_first_irpc", 32'(ir_pc), 32'd0);
        check("ar_first_valid", 32'(ir_valid), 32'd1);

        // Fault on the MEM_DEPTH=4 instance
        run_f = 1'b1; rdy_f = 1'b1;
        @(posedge clk);
        #1;
        rst_f_n = 1'b1;
        last_pc = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ir_valid_f) last_pc = int'(ir_pc_f);
            if (fault_f) break;
        end
        check("flt_fault", 32'(fault_f), 32'd1);
        check("flt_last_pc", 32'(last_pc), 32'd3);
        check("flt_ra", 32'(ra_f), 32'd4);
        check("flt_count", 32'(cnt_f), 32'd4);
        check("flt_drained", 32'(ir_valid_f), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flt_sticky", 32'(fault_f), 32'd1);
        check("flt_ra_kept", 32'(ra_f), 32'd4);

        // fetch_count saturation: endless two-instruction loop at 30/31
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[31] = 8'hC2;
        do_reset();
        run = 1'b1; ir_ready = 1'b1;
        repeat (300) cycle();
        check("sat_count", 32'(fetch_count), 32'd255);

        // Random programs with random run / ready traffic
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
            do_reset();
            for (int c = 0; c < 250; c++) begin
                run      = ($urandom_range(0, 7) != 0);
                ir_ready = ($urandom_range(0, 3) != 0);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch stage directly upstream of the instruction memory in the 8-bit microprocessor.
- Drives the combinational IMEM read address and registers the returned byte into an instruction register (IR).
- Hands the IR to the decode/control stage over a valid/ready handshake.
- Resolves jumps locally, next-PC = PC+1+sext(imm2), and detects jump-to-self halt and out-of-range fetch.

Parameters:
- MEM_DEPTH, 32, number of populated IMEM entries; fetch at PC >= MEM_DEPTH is a fault.
- PC_RESET, 8'h00, PC value after reset.
- LOOP_HALT, 1, 1 = a jump whose target equals its own PC enters HALT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable; 0 freezes PC without dropping the IR.
- read_address  out  8  IMEM address; equals the PC register.
- instruction  in  8  IMEM data, combinational from read_address; fields [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm.
- ir  out  8  registered instruction to decode.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir this cycle.
- ir_pc  out  8  PC the current ir was fetched from.
- halted  out  1  HALT state reached.
- fault  out  1  out-of-range fetch attempted.
- fetch_count  out  8  instructions issued, saturating at 255.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: PC=PC_RESET, ir=8'h00, ir_valid=0, ir_pc=0, halted=0, fault=0, fetch_count=0, state=IDLE.
- Reset mid-operation: the same asynchronous clear, immediately, regardless of state.
- States: IDLE, RUN, HALT, FAULT.
- IDLE -> RUN: on run=1. RUN -> IDLE: on run=0, with PC, ir and ir_valid unchanged.
- Issue condition: state=RUN, run=1, and (ir_valid=0 or ir_ready=1).
- On issue, at the clock edge:
  - ir <= instruction; ir_pc <= PC; ir_valid <= 1; fetch_count++ (saturating).
  - PC update when op==2'b11: PC <= PC+1+{{6{imm[1]}},imm}, mod 256.
  - PC update otherwise: PC <= PC+1, mod 256; 8'hFF wraps to 8'h00.
- Jumps are forwarded on ir so decode can suppress writeback.
- Latency: the byte at address A appears on ir exactly one cycle after the edge that issues A. There are no bubbles while ir_ready=1.
- Consume without issue: ir_valid=1, ir_ready=1 and no issue (run=0, HALT or FAULT) -> ir_valid <= 0.
- Stall: ir_valid=1 and ir_ready=0 -> ir, ir_pc and PC hold; no issue.
- Halt: LOOP_HALT=1 and an issued jump has target == PC.
  - That jump is still issued.
  - Next state is HALT and halted=1. Fetch stops; ir drains normally.
  - Exit only by reset.
- Fault: state=RUN, run=1, PC >= MEM_DEPTH.
  - No issue.
  - Next state FAULT, fault=1; PC is kept for debug.
  - Exit only by reset. The fault check takes priority over the issue condition.
- Simultaneous stall and halt-jump: the jump is not yet issued, so halt is taken only when it actually issues.
- read_address is driven from the PC register only, never combinationally from ir_ready.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11;
  - field bit positions;
  - ADDR_W=8, INSTR_W=8;
  - state encoding for fetch_unit.
- One natural sub-module, next_pc: combinational, taking PC and instruction and returning next_pc and is_self_jump. It is reusable by a later branch-predict or debug stage.

Test Plan:
- Boot trace: bench IMEM holds 0:0x49, 1:0xC1, 3:0xA9, 13:0xC3 (others as the team program); reset, run=1, ir_ready=1 held.
  -> ir_pc sequence 0,1,3,4,...,12,13.
  -> ir sequence starts 0x49, 0xC1, 0xA9.
  -> halted=1 the cycle after 0xC3 issues; fetch_count=13.
- Jump +1 at PC1: 0xC1 issued -> next read_address=3; address 2 never issued.
- Backpressure: ir_ready=0 for 3 cycles while ir=0x49 is valid -> ir, ir_pc=0 and read_address=1 stable. The first cycle with ir_ready=1 issues 0xC1.
- Run gating: run=0 at PC=5 -> PC holds at 5; a pending ir drains with ir_ready=1, then ir_valid=0. run=1 resumes with ir_pc=5.
- Fault: MEM_DEPTH=4, program 0x00 at addresses 0..3 -> after ir_pc=3, fault=1, read_address=4, ir_valid drops after consume, fetch_count=4.
- Async reset: assert reset_n=0 between edges while in RUN at PC=7 -> all outputs reset immediately. After release, the first issue has ir_pc=0.
